// File: rtl/instr_fetch_buffer.sv
// Fetch buffer: issues PC reads to in-order variable-latency memory, queues {pc, instr} for decode.
// Optional IFB_ALIGN_CHECK_EN: misaligned PCs skip memory and enqueue NOP with out_misalign set.
module instr_fetch_buffer #(
  parameter int unsigned      WIDTH = 32,
  parameter int unsigned      DEPTH = 4,
  parameter logic [WIDTH-1:0] NOP   = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_pc,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_instr
`ifdef IFB_ALIGN_CHECK_EN
  ,
  output logic             out_misalign
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW:0] DepthExt = (CntW + 1)'(DEPTH);

  logic [WIDTH-1:0] fifo_pc_q    [DEPTH];
  logic [WIDTH-1:0] fifo_instr_q [DEPTH];
  logic [WIDTH-1:0] tag_q        [DEPTH];
`ifdef IFB_ALIGN_CHECK_EN
  logic             fifo_mis_q   [DEPTH];
`endif

  logic [PtrW-1:0] out_rd_q, out_rd_d, out_wr_q, out_wr_d;
  logic [PtrW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [CntW-1:0] count_q, count_d, pending_q, pending_d, drop_q, drop_d;

  logic             credit, pc_misalign, fire, align_accept;
  logic             rsp, rsp_keep, rsp_drop, push, pop;
  logic [WIDTH-1:0] push_pc, push_instr;

  always_comb begin
    credit = ({1'b0, count_q} + {1'b0, pending_q}) < DepthExt;
`ifdef IFB_ALIGN_CHECK_EN
    pc_misalign = in_pc[1:0] != 2'b00;
`else
    pc_misalign = 1'b0;
`endif
    imem_req     = in_valid & credit & ~flush & ~rst & ~pc_misalign;
    imem_addr    = in_pc;
    fire         = imem_req & imem_gnt;
    // Misaligned PCs wait for the memory pipe to empty so output order stays in PC order.
    align_accept = in_valid & pc_misalign & (pending_q == '0) & credit & ~flush & ~rst;
    in_ready     = fire | align_accept;

    rsp      = imem_rvalid & (pending_q != '0);
    rsp_drop = rsp & (drop_q != '0);
    rsp_keep = rsp & (drop_q == '0) & ~flush;
    push     = rsp_keep | align_accept;
    push_pc    = align_accept ? in_pc : tag_q[tag_rd_q];
    push_instr = align_accept ? NOP : imem_rdata;

    out_valid = count_q != '0;
    pop       = out_valid & out_ready & ~flush;
    out_pc    = out_valid ? fifo_pc_q[out_rd_q] : '0;
    out_instr = out_valid ? fifo_instr_q[out_rd_q] : '0;
`ifdef IFB_ALIGN_CHECK_EN
    out_misalign = out_valid & fifo_mis_q[out_rd_q];
`endif
  end

  always_comb begin
    out_rd_d  = out_rd_q;
    out_wr_d  = out_wr_q;
    tag_rd_d  = tag_rd_q;
    tag_wr_d  = tag_wr_q;
    count_d   = count_q;
    drop_d    = drop_q;
    pending_d = pending_q + CntW'(fire) - CntW'(rsp);
    if (flush) begin
      out_rd_d = '0;
      out_wr_d = '0;
      tag_rd_d = '0;
      tag_wr_d = '0;
      count_d  = '0;
      // Every request still outstanding after this cycle belongs to the abandoned stream.
      drop_d   = pending_q - CntW'(rsp);
    end else begin
      if (push)     out_wr_d = out_wr_q + 1'b1;
      if (pop)      out_rd_d = out_rd_q + 1'b1;
      if (fire)     tag_wr_d = tag_wr_q + 1'b1;
      if (rsp_keep) tag_rd_d = tag_rd_q + 1'b1;
      if (rsp_drop) drop_d   = drop_q - CntW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_rd_q  <= '0;
      out_wr_q  <= '0;
      tag_rd_q  <= '0;
      tag_wr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      drop_q    <= '0;
    end else begin
      out_rd_q  <= out_rd_d;
      out_wr_q  <= out_wr_d;
      tag_rd_q  <= tag_rd_d;
      tag_wr_q  <= tag_wr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      tag_q[tag_wr_q] <= in_pc;
    end
    if (push) begin
      fifo_pc_q[out_wr_q]    <= push_pc;
      fifo_instr_q[out_wr_q] <= push_instr;
`ifdef IFB_ALIGN_CHECK_EN
      fifo_mis_q[out_wr_q]   <= align_accept;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: in-order memory model plus output scoreboard.
module tb_instr_fetch_buffer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, imem_req, imem_gnt, imem_rvalid;
  logic        out_valid, out_ready;
  logic [31:0] in_pc, imem_addr, imem_rdata, out_pc, out_instr;
`ifdef IFB_ALIGN_CHECK_EN
  logic        out_misalign;
`endif

  instr_fetch_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_pc       (in_pc),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
`ifdef IFB_ALIGN_CHECK_EN
    .out_misalign(out_misalign),
`endif
    .out_instr   (out_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mem_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          mis;
    int          vis;
  } exp_t;

  mem_t        mem_q[$];
  exp_t        exp_q[$];
  int          cyc = 0;
  int          lat = 1;
  int          vectors = 0;
  int          miscompares = 0;
  int          n_out = 0;
  int          n_fire = 0;
  bit          chk_en = 1'b0;
  logic [31:0] last_pc = '0;

  // One clock: check outputs against the scoreboard, advance, then update memory/scoreboard.
  task automatic step();
    logic        ov, rq, gn, rv, fl, ordy, ir;
    logic [31:0] addr, pcv;
    bit          vis;
    exp_t        e;
    mem_t        m;
    #1;
    ov = out_valid; rq = imem_req; gn = imem_gnt; rv = imem_rvalid;
    fl = flush; ordy = out_ready; ir = in_ready; addr = imem_addr; pcv = in_pc;
    if (chk_en) begin
      vis = (exp_q.size() != 0) && (exp_q[0].vis <= cyc);
      vectors++;
      if (out_valid !== vis) begin
        miscompares++;
        $display("FAIL out_valid cyc=%0d got=%b want=%b", cyc, out_valid, vis);
      end else if (vis) begin
        vectors++;
        if (out_pc !== exp_q[0].pc || out_instr !== exp_q[0].instr
`ifdef IFB_ALIGN_CHECK_EN
            || out_misalign !== exp_q[0].mis
`endif
            ) begin
          miscompares++;
          $display("FAIL out_entry cyc=%0d got=(%h,%h) want=(%h,%h)", cyc, out_pc, out_instr,
                   exp_q[0].pc, exp_q[0].instr);
        end
      end else begin
        vectors++;
        if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
          miscompares++;
          $display("FAIL empty_zero cyc=%0d got=(%h,%h) want=(0,0)", cyc, out_pc, out_instr);
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      mem_q.delete();
      exp_q.delete();
    end else begin
      if (ov === 1'b1 && ordy && !fl && exp_q.size() != 0) begin
        last_pc = exp_q[0].pc;
        exp_q.delete(0);
        n_out++;
      end
      if (rv && mem_q.size() != 0) begin
        if (!mem_q[0].stale && !fl) begin
          e.pc = mem_q[0].addr; e.instr = mem_q[0].addr ^ KEY; e.mis = 1'b0; e.vis = cyc + 1;
          exp_q.push_back(e);
        end
        mem_q.delete(0);
      end
      if (fl) begin
        exp_q.delete();
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      end
      if (rq === 1'b1 && gn) begin
        m.addr = addr; m.due = cyc + lat; m.stale = 1'b0;
        mem_q.push_back(m);
        n_fire++;
      end
`ifdef IFB_ALIGN_CHECK_EN
      if (ir === 1'b1 && pcv[1:0] != 2'b00) begin
        e.pc = pcv; e.instr = NOP; e.mis = 1'b1; e.vis = cyc + 1;
        exp_q.push_back(e);
      end
`endif
    end
    cyc++;
    if (!rst && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].addr ^ KEY;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_pc = 32'h40; flush = 1'b0; out_ready = 1'b0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (imem_req !== 1'b0) begin
        miscompares++; $display("FAIL rst_imem_req got=%b want=0", imem_req);
      end
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++; $display("FAIL rst_in_ready got=%b want=0", in_ready);
      end
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++; $display("FAIL rst_out_valid got=%b want=0", out_valid);
      end
      vectors++;
      if (out_pc !== 32'h0) begin
        miscompares++; $display("FAIL rst_out_pc got=%h want=0", out_pc);
      end
      vectors++;
      if (out_instr !== 32'h0) begin
        miscompares++; $display("FAIL rst_out_instr got=%h want=0", out_instr);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
    chk_en = 1'b1;
    step();
  endtask

  task automatic test_streaming();
    int n0;
    lat = 1; out_ready = 1'b1; n0 = n_out;
    for (int i = 0; i < 4; i++) begin
      in_pc = 32'(i * 4); in_valid = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++; $display("FAIL stream_ready pc=%h got=%b want=1", in_pc, in_ready);
      end
      vectors++;
      if (imem_addr !== in_pc) begin
        miscompares++; $display("FAIL stream_addr got=%h want=%h", imem_addr, in_pc);
      end
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();
    vectors++;
    if (n_out - n0 != 4) begin
      miscompares++; $display("FAIL stream_count got=%0d want=4", n_out - n0);
    end
  endtask

  task automatic test_backpressure();
    int idx, f0, n0;
    bit exp_r;
    lat = 1; out_ready = 1'b0; idx = 0; f0 = n_fire; n0 = n_out;
    for (int c = 0; c < 8; c++) begin
      in_pc = 32'h200 + 32'(idx * 4); in_valid = 1'b1;
      #1;
      exp_r = (idx < DEPTH);
      vectors++;
      if (in_ready !== exp_r) begin
        miscompares++; $display("FAIL bp_ready c=%0d got=%b want=%b", c, in_ready, exp_r);
      end
      if (exp_r) idx++;
      step();
    end
    vectors++;
    if (n_fire - f0 != 4) begin
      miscompares++; $display("FAIL bp_fires got=%0d want=4", n_fire - f0);
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL bp_pop_cycle_ready got=%b want=0", in_ready);
    end
    step();
    out_ready = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_resume_ready got=%b want=1", in_ready);
    end
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) step();
    vectors++;
    if (n_out - n0 != 5) begin
      miscompares++; $display("FAIL bp_drain got=%0d want=5", n_out - n0);
    end
  endtask

  task automatic test_flush();
    int n0;
    lat = 3; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_pc = 32'h300 + 32'(i * 4); in_valid = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++; $display("FAIL flush_setup_ready i=%0d got=%b want=1", i, in_ready);
      end
      step();
    end
    flush = 1'b1; in_pc = 32'h100; in_valid = 1'b1;
    #1;
    vectors++;
    if (imem_req !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_no_fire got req=%b rdy=%b want 0,0", imem_req, in_ready);
    end
    step();
    flush = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL flush_refetch_ready got=%b want=1", in_ready);
    end
    n0 = n_out;
    step();
    in_valid = 1'b0;
    repeat (8) step();
    vectors++;
    if (n_out - n0 != 1 || last_pc !== 32'h100) begin
      miscompares++;
      $display("FAIL flush_first_out got n=%0d pc=%h want n=1 pc=00000100", n_out - n0, last_pc);
    end
  endtask

  task automatic test_simultaneous();
    int n0;
    lat = 1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_pc = 32'h400 + 32'(i * 4); in_valid = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++; $display("FAIL sim_ready i=%0d got=%b want=1", i, in_ready);
      end
      step();
      // Hold the third PC until two entries sit in the FIFO.
      if (i == 1) begin
        in_valid = 1'b0;
        step();
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n0 = n_out;
    step();
    out_ready = 1'b0;
    #1;
    vectors++;
    if (out_pc !== 32'h404) begin
      miscompares++; $display("FAIL sim_head got=%h want=00000404", out_pc);
    end
    out_ready = 1'b1;
    repeat (2) step();
    #1;
    vectors++;
    if (n_out - n0 != 3 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL sim_count got pops=%0d valid=%b want 3,0", n_out - n0, out_valid);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_pc = 32'h500 + 32'(i * 4); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    #1;
    vectors++;
    if (imem_rvalid !== 1'b1 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL sim_flush_setup got rv=%b ov=%b want 1,1", imem_rvalid, out_valid);
    end
    step();
    flush = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL sim_flush_empty got=%b want=0", out_valid);
    end
    n0 = n_out;
    in_pc = 32'h600; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    vectors++;
    if (n_out - n0 != 1 || last_pc !== 32'h600) begin
      miscompares++;
      $display("FAIL sim_after_flush got n=%0d pc=%h want n=1 pc=00000600", n_out - n0, last_pc);
    end
  endtask

`ifdef IFB_ALIGN_CHECK_EN
  task automatic test_align();
    lat = 1; out_ready = 1'b0; in_pc = 32'h102; in_valid = 1'b1;
    #1;
    vectors++;
    if (imem_req !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL align_accept got req=%b rdy=%b want 0,1", imem_req, in_ready);
    end
    step();
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 32'h102 || out_instr !== NOP || out_misalign !== 1'b1)
      begin
      miscompares++;
      $display("FAIL align_entry got v=%b pc=%h instr=%h mis=%b want 1,102,13,1", out_valid,
               out_pc, out_instr, out_misalign);
    end
    out_ready = 1'b1;
    repeat (3) step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_simultaneous();
`ifdef IFB_ALIGN_CHECK_EN
    test_align();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
